// File: rtl/tiny32_mem_responder_if.sv
// tiny32 CPU memory bus bundle: the CPU (master) drives address/strobes/write data,
// the responder (slave) returns read data, the ready handshake and a conflict error pulse.
interface tiny32_mem_responder_if;
  logic [31:0] address;
  logic        nrd;
  logic [3:0]  nwr;
  logic [31:0] data_out;
  logic [31:0] rdata;
  logic        ready;
  logic        bus_err;

  modport master (
    output address, nrd, nwr, data_out,
    input  rdata, ready, bus_err
  );

  modport slave (
    input  address, nrd, nwr, data_out,
    output rdata, ready, bus_err
  );
endinterface

// File: rtl/tiny32_mem_responder.sv
// tiny32 memory-bus responder: one 256 MB window backed by a word RAM with byte-lane
// writes, programmable wait states and an OR-combinable (zero when idle) response.
module tiny32_mem_responder #(
  parameter int          ADDR_BITS   = 10,
  parameter logic [3:0]  BASE        = 4'h4,
  parameter int          WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    nreset,
  tiny32_mem_responder_if.slave   bus,
  output logic [1:0]              dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  // Handshake: a request is a selected address with exactly one strobe class low;
  // ready answers it once, and the strobes must be released before the next one.
  logic sel, rd_req, wr_req, conflict, released;
  logic [ADDR_BITS-1:0] live_idx;
  logic addr_unused;

  assign sel      = (bus.address[31:28] == BASE);
  assign rd_req   = sel & ~bus.nrd & (bus.nwr == 4'hF);
  assign wr_req   = sel &  bus.nrd & (bus.nwr != 4'hF);
  assign conflict = sel & ~bus.nrd & (bus.nwr != 4'hF);
  assign released = bus.nrd & (bus.nwr == 4'hF);
  assign live_idx = bus.address[ADDR_BITS+1:2];
  assign addr_unused = ^{bus.address[27:ADDR_BITS+2], bus.address[1:0]};

  logic [31:0] mem [2**ADDR_BITS];

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [3:0]           mask_q, mask_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 is_wr_q, is_wr_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 bus_err_q, bus_err_d;

  logic                 acc_fire, acc_wr, mem_we;
  logic [ADDR_BITS-1:0] acc_idx;
  logic [3:0]           acc_mask;
  logic [31:0]          acc_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    acc_fire  = 1'b0;
    acc_wr    = is_wr_q;
    acc_idx   = idx_q;
    acc_mask  = mask_q;
    acc_wdata = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (conflict) begin
          bus_err_d = 1'b1;
          state_d   = ST_HOLD;
        end else if (rd_req || wr_req) begin
          idx_d   = live_idx;
          mask_d  = ~bus.nwr;
          wdata_d = bus.data_out;
          is_wr_d = wr_req;
          if (WAIT_STATES == 0) begin
            // Zero wait states: the access uses the live bus in the same edge it is captured.
            acc_fire  = 1'b1;
            acc_wr    = wr_req;
            acc_idx   = live_idx;
            acc_mask  = ~bus.nwr;
            acc_wdata = bus.data_out;
            state_d   = ST_ACK;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (released || !sel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          acc_fire = 1'b1;
          state_d  = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: state_d = ST_HOLD;
      ST_HOLD: begin
        if (released) begin
          rdata_d = 32'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (acc_fire) rdata_d = acc_wr ? 32'd0 : mem[acc_idx];
  end

  // Gated by nreset so a request present while reset is held never lands in the RAM.
  assign mem_we = acc_fire & acc_wr & nreset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      mask_q    <= 4'd0;
      wdata_q   <= 32'd0;
      is_wr_q   <= 1'b0;
      rdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.ready   = (state_q == ST_ACK);
  assign bus.bus_err = bus_err_q;
  assign dbg_state   = state_q;

endmodule
